// File: rtl/uart_rx.sv
// uart_rx: UART receiver (1 start bit, gonbitsys data bits LSB first, c_stopbit stop bits).
// Optional macro UART_RX_MAJORITY_EN: 2-of-3 majority vote of rx_s at every sample point.
module uart_rx #(
   parameter int unsigned c_clkfreq  = 100_000_000,
   parameter int unsigned c_baudrate = 10_000_000,
   parameter int unsigned c_stopbit  = 2,
   parameter int unsigned gonbitsys  = 10
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx_i,
   output logic [gonbitsys-1:0] dout_o,
   output logic                 rx_done_tick_o,
   output logic                 frame_err_o
);

   localparam int unsigned N       = c_clkfreq / c_baudrate;
   localparam int unsigned H       = N / 2;
   localparam int unsigned TIMER_W = (N > 1) ? $clog2(N) : 1;
   localparam int unsigned CNT_MAX = (gonbitsys > c_stopbit) ? gonbitsys : c_stopbit;
   localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

   localparam logic [TIMER_W-1:0] TIMER_HALF = TIMER_W'(H - 1);
   localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(N - 1);
   localparam logic [CNT_W-1:0]   DATA_LAST  = CNT_W'(gonbitsys - 1);
   localparam logic [CNT_W-1:0]   STOP_LAST  = CNT_W'(c_stopbit - 1);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_START     = 3'd1,
      S_DATA      = 3'd2,
      S_STOP      = 3'd3,
      S_WAIT_HIGH = 3'd4
   } state_t;

   state_t               state, state_nxt;
   logic [TIMER_W-1:0]   bittimer, bittimer_nxt;
   logic [CNT_W-1:0]     bitcntr, bitcntr_nxt;
   logic [gonbitsys-1:0] shreg, shreg_nxt;
   logic [gonbitsys-1:0] dout_nxt;
   logic                 done_nxt;
   logic                 err_nxt;

   logic rx_meta;
   logic rx_s;
   logic sample_c;

   // two-flop synchronizer; idles high so reset never looks like a start bit
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= rx_i;
         rx_s    <= rx_meta;
      end
   end

`ifdef UART_RX_MAJORITY_EN
   logic rx_d1;
   logic rx_d2;

   // history of the two cycles preceding the sample point
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_d1 <= 1'b1;
         rx_d2 <= 1'b1;
      end else begin
         rx_d1 <= rx_s;
         rx_d2 <= rx_d1;
      end
   end

   assign sample_c = (rx_s & rx_d1) | (rx_s & rx_d2) | (rx_d1 & rx_d2);
`else
   assign sample_c = rx_s;
`endif

   // state and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= S_IDLE;
         bittimer       <= '0;
         bitcntr        <= '0;
         shreg          <= '0;
         dout_o         <= '0;
         rx_done_tick_o <= 1'b0;
         frame_err_o    <= 1'b0;
      end else begin
         state          <= state_nxt;
         bittimer       <= bittimer_nxt;
         bitcntr        <= bitcntr_nxt;
         shreg          <= shreg_nxt;
         dout_o         <= dout_nxt;
         rx_done_tick_o <= done_nxt;
         frame_err_o    <= err_nxt;
      end
   end

   // next-state and datapath logic
   always_comb begin
      state_nxt    = state;
      bittimer_nxt = bittimer;
      bitcntr_nxt  = bitcntr;
      shreg_nxt    = shreg;
      dout_nxt     = dout_o;
      done_nxt     = 1'b0;
      err_nxt      = 1'b0;

      case (state)
         S_IDLE: begin
            bittimer_nxt = '0;
            bitcntr_nxt  = '0;
            if (!rx_s) begin
               state_nxt = S_START;
            end
         end

         // confirm the start bit half a bit in; a high sample is a glitch
         S_START: begin
            if (bittimer == TIMER_HALF) begin
               bittimer_nxt = '0;
               state_nxt    = sample_c ? S_IDLE : S_DATA;
            end else begin
               bittimer_nxt = bittimer + TIMER_W'(1);
            end
         end

         S_DATA: begin
            if (bittimer == TIMER_LAST) begin
               bittimer_nxt = '0;
               shreg_nxt    = {sample_c, shreg[gonbitsys-1:1]};
               if (bitcntr == DATA_LAST) begin
                  bitcntr_nxt = '0;
                  state_nxt   = S_STOP;
               end else begin
                  bitcntr_nxt = bitcntr + CNT_W'(1);
               end
            end else begin
               bittimer_nxt = bittimer + TIMER_W'(1);
            end
         end

         // leave at mid last stop bit so the next start edge is not missed
         S_STOP: begin
            if (bittimer == TIMER_LAST) begin
               bittimer_nxt = '0;
               if (!sample_c) begin
                  err_nxt     = 1'b1;
                  bitcntr_nxt = '0;
                  state_nxt   = S_WAIT_HIGH;
               end else if (bitcntr == STOP_LAST) begin
                  dout_nxt    = shreg;
                  done_nxt    = 1'b1;
                  bitcntr_nxt = '0;
                  state_nxt   = S_IDLE;
               end else begin
                  bitcntr_nxt = bitcntr + CNT_W'(1);
               end
            end else begin
               bittimer_nxt = bittimer + TIMER_W'(1);
            end
         end

         // a stuck-low line must return high before another start is accepted
         S_WAIT_HIGH: begin
            bittimer_nxt = '0;
            bitcntr_nxt  = '0;
            if (rx_s) begin
               state_nxt = S_IDLE;
            end
         end

         default: begin
            bittimer_nxt = '0;
            bitcntr_nxt  = '0;
            state_nxt    = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized scoreboard bench for uart_rx with a bit-level line driver.
// Expected words/timing come from frame arithmetic; a monitor pops them on every output pulse.
module tb_uart_rx;

   localparam int unsigned CLKFREQ = 100_000_000;
   localparam int unsigned BAUD    = 10_000_000;
   localparam int unsigned NSTOP   = 2;
   localparam int unsigned NBITS   = 10;
   localparam int N     = int'(CLKFREQ / BAUD);
   localparam int H     = N / 2;
   localparam int FRAME = 1 + NBITS + NSTOP;
`ifdef UART_RX_MAJORITY_EN
   localparam bit MAJ = 1'b1;
`else
   localparam bit MAJ = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst;
   logic             rx_i;
   logic [NBITS-1:0] dout;
   logic             tick;
   logic             ferr;

   int cyc    = 0;
   int checks = 0;
   int errors = 0;
   logic [NBITS-1:0] last_good;

   typedef struct {
      bit               good;
      logic [NBITS-1:0] data;
      int               when;
   } exp_t;
   exp_t sb[$];

   uart_rx #(
      .c_clkfreq (CLKFREQ),
      .c_baudrate(BAUD),
      .c_stopbit (NSTOP),
      .gonbitsys (NBITS)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .rx_i          (rx_i),
      .dout_o        (dout),
      .rx_done_tick_o(tick),
      .frame_err_o   (ferr)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         rx_i = 1'b1;
      end
   endtask

   // Drive nbits bit-periods of a frame (start, data LSB first, stops); a full
   // frame also pushes the expected response. glitch_t inverts the line for one cycle.
   task automatic send_frame(input logic [NBITS-1:0] d, input logic [NSTOP-1:0] stops,
                             input int nbits, input int glitch_t);
      logic [FRAME-1:0] bits;
      logic [NBITS-1:0] seen;
      exp_t e;
      int   bad_j;
      bits  = {stops, d, 1'b0};
      seen  = d;
      if (!MAJ)
         for (int i = 0; i < int'(NBITS); i++)
            if (glitch_t == H + (i + 1) * N) seen[i] = ~seen[i];
      bad_j = -1;
      for (int j = int'(NSTOP) - 1; j >= 0; j--)
         if (!stops[j]) bad_j = j;
      for (int t = 0; t < nbits * N; t++) begin
         @(negedge clk);
         if (t == 0 && nbits == FRAME) begin
            e.good = (bad_j < 0);
            if (e.good) begin
               e.data    = seen;
               e.when    = cyc + 3 + H + (int'(NBITS) + int'(NSTOP)) * N;
               last_good = seen;
            end else begin
               e.data = last_good;
               e.when = cyc + 3 + H + (int'(NBITS) + 1 + bad_j) * N;
            end
            sb.push_back(e);
         end
         rx_i = bits[t / N] ^ (t == glitch_t);
      end
   endtask

   // monitor: every output pulse must match the oldest expected response
   always @(negedge clk) begin
      exp_t e;
      if (!rst && (tick || ferr)) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pulse: tick=%0b err=%0b dout=0x%0h, expected no pulse (cycle %0d)",
                     tick, ferr, dout, cyc);
         end else begin
            e = sb.pop_front();
            check("pulse_kind", int'({tick, ferr}), e.good ? 2 : 1);
            check("dout", int'(dout), int'(e.data));
            check("pulse_cycle", cyc, e.when);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [NBITS-1:0] d;
      logic [NSTOP-1:0] st;
      rst       = 1'b1;
      rx_i      = 1'b1;
      last_good = '0;
      repeat (3) @(negedge clk);
      check("reset_dout", int'(dout), 0);
      check("reset_tick", int'(tick), 0);
      check("reset_err", int'(ferr), 0);
      rst = 1'b0;
      idle(5);

      // basic frame
      send_frame(10'h2A5, 2'b11, FRAME, -1);
      idle(20);
      check("hold_2a5", int'(dout), 'h2A5);

      // short low pulse is rejected, receiver ready again shortly after
      @(negedge clk);
      rx_i = 1'b0;
      repeat (3) @(negedge clk);
      rx_i = 1'b1;
      idle(4);
      send_frame(10'h0AA, 2'b11, FRAME, -1);
      idle(10);

      // second stop bit low, line then held low: one error, no restart
      send_frame(10'h155, 2'b01, FRAME, -1);
      repeat (50) begin
         @(negedge clk);
         rx_i = 1'b0;
      end
      idle(20);
      check("hold_after_err", int'(dout), 'h0AA);

      // back-to-back frames
      send_frame(10'h000, 2'b11, FRAME, -1);
      send_frame(10'h3FF, 2'b11, FRAME, -1);
      send_frame(10'h0F0, 2'b11, FRAME, -1);
      idle(20);

      // reset mid-data abandons the frame and clears dout
      send_frame(10'h1FF, 2'b11, 5, -1);
      @(negedge clk);
      rst  = 1'b1;
      rx_i = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midreset_dout", int'(dout), 0);
      check("midreset_tick", int'(tick), 0);
      check("midreset_err", int'(ferr), 0);
      last_good = '0;
      idle(20);
      send_frame(10'h003, 2'b11, FRAME, -1);
      idle(20);

      // one-cycle glitch at data bit 4's sample point
      send_frame(10'h000, 2'b11, FRAME, H + 5 * N);
      idle(20);
      check("glitch_dout", int'(dout), MAJ ? 'h000 : 'h010);

      // random frames with occasional bad stop bits and random gaps
      for (int n = 0; n < 20; n++) begin
         d  = NBITS'($urandom);
         st = ($urandom_range(0, 4) == 0) ? NSTOP'($urandom_range(0, 2)) : '1;
         send_frame(d, st, FRAME, -1);
         if (st != '1) idle(N);
         idle(int'($urandom_range(0, 12)));
      end

      for (int i = 0; i < 400 && sb.size() != 0; i++) @(negedge clk);
      check("scoreboard_drained", sb.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver: deserializes an asynchronous serial line (idle high, one start bit, `gonbitsys` data bits LSB first, `c_stopbit` stop bits) into a parallel word. It is the receiving end for `uart_tx` and uses the same parameter set, so a loopback of `uart_tx.tx_o` into `uart_rx.rx_i` with identical parameters recovers `din_i` exactly. It sits at the chip's serial pin boundary and feeds parallel consumers via a one-cycle done tick.

## Interface
- `c_clkfreq`, 100_000_000, system clock frequency in Hz
- `c_baudrate`, 10_000_000, line bit rate; `N = c_clkfreq/c_baudrate` clocks per bit, must be ≥4
- `c_stopbit`, 2, number of stop bits checked per frame (≥1)
- `gonbitsys`, 10, data bits per frame
- `clk` in 1, sole clock
- `rst` in 1, synchronous, active-high reset
- `rx_i` in 1, asynchronous serial input
- `dout_o` out `gonbitsys`, last correctly framed word, bit 0 = first received data bit
- `rx_done_tick_o` out 1, one-cycle pulse: `dout_o` updated with a good frame
- `frame_err_o` out 1, one-cycle pulse: a stop bit was sampled low; `dout_o` unchanged

## Operation
- `rx_i` passes a 2-flop synchronizer → `rx_s`; both flops reset to 1.
- `H = N/2` (integer divide). `bittimer` counts 0..N-1, `bitcntr` counts bits; widths are `$clog2` of their limits.
- S_IDLE: `bittimer=0`, `bitcntr=0`. `rx_s==0` → S_START.
- S_START: at `bittimer==H-1`, sample `rx_s`: 0 → S_DATA, `bittimer=0`; 1 → S_IDLE (glitch rejected, no output).
- S_DATA: at `bittimer==N-1`, shift sample into `shreg` MSB (right shift), `bitcntr++`, `bittimer=0`; after the `gonbitsys`-th sample → S_STOP, `bitcntr=0`.
- S_STOP: at `bittimer==N-1`, sample the stop bit. Sample 0 → pulse `frame_err_o`, → S_WAIT_HIGH. Sample 1 and not last stop bit → stay, `bitcntr++`. Sample 1 and last → `dout_o<=shreg`, pulse `rx_done_tick_o`, → S_IDLE.
- S_WAIT_HIGH: stay until `rx_s==1`, then → S_IDLE (a break/stuck-low line does not produce repeated frames).
- Receiver returns to S_IDLE at mid-last-stop-bit, giving half a bit of tolerance for transmitter clock skew on back-to-back frames.
- Illegal state encoding → S_IDLE.

## Timing
- Reset values: `dout_o=0`, `rx_done_tick_o=0`, `frame_err_o=0`, state S_IDLE, counters 0, `shreg=0`.
- Reset mid-frame: frame abandoned, no tick, no error; `dout_o` cleared.
- Cycle `k` = first cycle `rx_s==0` in S_IDLE (`rx_i` fall + 2 clocks). Start sampled at `k+H`; data bit `i` (0-based) at `k+H+(i+1)N`; stop bit `j` at `k+H+(gonbitsys+1+j)N`.
- `rx_done_tick_o`/`frame_err_o` high exactly one cycle, the cycle after the deciding sample. Defaults: tick at `k+126`.
- Ticks are mutually exclusive. `rx_done_tick_o` and `dout_o` change in the same cycle.
- Next frame's start is detectable the cycle after the tick.

## Configuration
- `UART_RX_MAJORITY_EN` defined: each sample (start, data, stop) is the 2-of-3 majority of `rx_s` at the sample cycle and the two preceding cycles; a single-cycle glitch at the sample point is filtered. Sample timing and latency are unchanged.
- Undefined: a single sample of `rx_s` at the sample cycle; no extra flops.

## Test plan
- Defaults, `uart_tx` loopback sends `0x2A5` → exactly one `rx_done_tick_o`, `dout_o=0x2A5`, `frame_err_o` never high.
- `rx_i` low for 3 cycles, then high → no tick, no error, FSM in S_IDLE after 7 cycles.
- Frame `0x155` with second stop bit forced low, line then held low 50 cycles → one `frame_err_o` pulse, `dout_o` holds the previous value, no start detected until `rx_i` returns high.
- Three back-to-back loopback frames `0x000`, `0x3FF`, `0x0F0` → three ticks, with values in order, spacing 130 cycles.
- `rst` asserted mid-data of frame `0x1FF`, then a clean frame `0x003` → no tick for the first frame, `dout_o=0` after reset, then `dout_o=0x003`.
- With `UART_RX_MAJORITY_EN`, invert `rx_i` for one cycle aligned to bit 4's sample point of `0x000` → `dout_o=0x000`; without the macro → `dout_o=0x010`.
